// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - five-digit multiplexed 7-segment scanner with frame snapshot and blanking gap
module seven_seg_scan_driver #(
    parameter int TICK_DIV       = 100000,
    parameter int BLANK_CYCLES   = 1000,
    parameter int DP_DIGIT       = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] sign,
    input  logic [6:0] tens,
    input  logic [6:0] units,
    input  logic [6:0] tenths,
    input  logic [6:0] hundredths,
    input  logic       blank_i,
    output logic [6:0] seg,
    output logic       dp,
    output logic [4:0] an,
    output logic       frame_done
);

    localparam int             SCW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [SCW-1:0] SC_LAST   = SCW'(TICK_DIV - 1);
    localparam logic [SCW-1:0] BLANK_LIM = SCW'(BLANK_CYCLES);
    localparam logic [2:0]     DP_IDX    = 3'(DP_DIGIT);
    localparam logic [6:0]     SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic           DP_OFF    = (SEG_ACTIVE_LOW != 0);
    localparam logic [4:0]     AN_OFF    = (AN_ACTIVE_LOW != 0) ? 5'h1F : 5'h00;

    logic [SCW-1:0] sc_q, sc_d;
    logic [2:0]     idx_q, idx_d;
    logic [6:0]     sh_q [5];
    logic [6:0]     sh_d [5];
    logic [4:0]     an_q, an_d;
    logic [6:0]     seg_q, seg_d;
    logic           dp_q, dp_d;
    logic           fd_q, fd_d;

    logic           last_slot;
    logic           frame_end;
    logic           in_blank;
    logic [6:0]     pat;
    logic [4:0]     an_on;

    always_comb begin
        last_slot = (sc_q == SC_LAST);
        frame_end = last_slot && (idx_q == 3'd4);

        sc_d  = last_slot ? '0 : sc_q + SCW'(1);
        idx_d = idx_q;
        if (last_slot) begin
            idx_d = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
        end

        // Inputs are sampled once per frame so a digit never changes mid-scan.
        sh_d = sh_q;
        if (frame_end) begin
            sh_d[0] = hundredths;
            sh_d[1] = tenths;
            sh_d[2] = units;
            sh_d[3] = tens;
            sh_d[4] = sign;
        end

        case (idx_q)
            3'd0:    pat = sh_q[0];
            3'd1:    pat = sh_q[1];
            3'd2:    pat = sh_q[2];
            3'd3:    pat = sh_q[3];
            3'd4:    pat = sh_q[4];
            default: pat = 7'h00;
        endcase
        an_on = 5'b00001 << idx_q;

        in_blank = ((BLANK_CYCLES != 0) && (sc_q < BLANK_LIM)) || blank_i;

        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = DP_OFF;
        if (!in_blank) begin
            an_d  = (AN_ACTIVE_LOW != 0) ? ~an_on : an_on;
            seg_d = (SEG_ACTIVE_LOW != 0) ? ~pat : pat;
            dp_d  = (idx_q == DP_IDX) ? ~DP_OFF : DP_OFF;
        end

        fd_d = frame_end;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sc_q  <= '0;
            idx_q <= '0;
            sh_q  <= '{default: '0};
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
            dp_q  <= DP_OFF;
            fd_q  <= 1'b0;
        end else begin
            sc_q  <= sc_d;
            idx_q <= idx_d;
            sh_q  <= sh_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            fd_q  <= fd_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb/tb_seven_seg_scan_driver.sv - directed self-checking bench for seven_seg_scan_driver
module tb_seven_seg_scan_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] sign, tens, units, tenths, hundredths;
    logic       blank_i;
    logic [6:0] seg;
    logic       dp;
    logic [4:0] an;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    logic [6:0] exp_pat [5];

    seven_seg_scan_driver #(
        .TICK_DIV(8),
        .BLANK_CYCLES(2),
        .DP_DIGIT(2),
        .SEG_ACTIVE_LOW(1),
        .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sign(sign),
        .tens(tens),
        .units(units),
        .tenths(tenths),
        .hundredths(hundredths),
        .blank_i(blank_i),
        .seg(seg),
        .dp(dp),
        .an(an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    // Output index p is the p-th edge after frame start; slot = p/8, dark for first 2 cycles.
    task automatic run_frame(input string name, input bit snap_change, input bit do_blank, input int last_p);
        int         slot;
        int         s;
        bit         show;
        logic [4:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        for (int p = 0; p <= last_p; p++) begin
            @(posedge clk);
            #1;
            slot  = p / 8;
            s     = p % 8;
            show  = (s >= 2) && !(do_blank && p >= 28 && p <= 30);
            e_an  = show ? ~(5'b00001 << slot) : 5'b11111;
            e_seg = show ? ~exp_pat[slot] : 7'h7F;
            e_dp  = !(show && slot == 2);
            chk($sformatf("%s_an_p%0d", name, p), 32'(an), 32'(e_an));
            chk($sformatf("%s_seg_p%0d", name, p), 32'(seg), 32'(e_seg));
            chk($sformatf("%s_dp_p%0d", name, p), 32'(dp), 32'(e_dp));
            chk($sformatf("%s_fd_p%0d", name, p), 32'(frame_done), 32'(p == 39));
            if (snap_change && p == 8) units = 7'h3F;
            if (do_blank && p == 27) blank_i = 1'b1;
            if (do_blank && p == 30) blank_i = 1'b0;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        blank_i    = 1'b0;
        hundredths = 7'h01;
        tenths     = 7'h02;
        units      = 7'h04;
        tens       = 7'h08;
        sign       = 7'h40;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", 32'(an), 32'h1F);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_fd", 32'(frame_done), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) exp_pat[i] = 7'h00;
        run_frame("dark", 1'b0, 1'b0, 39);

        exp_pat[0] = 7'h01;
        exp_pat[1] = 7'h02;
        exp_pat[2] = 7'h04;
        exp_pat[3] = 7'h08;
        exp_pat[4] = 7'h40;
        run_frame("scan", 1'b1, 1'b0, 39);

        exp_pat[2] = 7'h3F;
        run_frame("blank", 1'b0, 1'b1, 39);

        run_frame("pre_rst", 1'b0, 1'b0, 27);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_an", 32'(an), 32'h1F);
        chk("midrst_seg", 32'(seg), 32'h7F);
        chk("midrst_dp", 32'(dp), 32'h1);
        chk("midrst_fd", 32'(frame_done), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) exp_pat[i] = 7'h00;
        run_frame("redark", 1'b0, 1'b0, 39);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
